// File: rtl/axis_tx_min_pad.sv
// axis_tx_min_pad: pads short AXI-Stream frames up to MIN_FRAME_LEN bytes
// (FCS excluded) before they reach the MAC transmitter. Frames that are
// already long enough pass through untouched. Output is fully registered,
// one cycle behind input acceptance.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_PASS  | forwarding input beats; short last beats padded in place
// ST_PAD   | input held off; emitting zero beats until the minimum is met
module axis_tx_min_pad #(
  parameter int DATA_WIDTH    = 64,
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int USER_W        = 1,
  parameter int MIN_FRAME_LEN = 60
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_W-1:0]     s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_W-1:0]     m_axis_tuser
);

  // Counter is wide enough for MIN_FRAME_LEN (max 248) plus one full beat.
  localparam int CW = 9;
  localparam logic [CW-1:0] MIN_LEN    = CW'(MIN_FRAME_LEN);
  localparam logic [CW-1:0] BEAT_BYTES = CW'(KEEP_WIDTH);

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_PAD  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [USER_W-1:0]     user_lat_q, user_lat_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [KEEP_WIDTH-1:0] m_keep_q, m_keep_d;
  logic                  m_valid_q, m_valid_d;
  logic                  m_last_q, m_last_d;
  logic [USER_W-1:0]     m_user_q, m_user_d;

  logic                  out_free;
  logic                  s_ready;
  logic                  s_fire;
  logic [CW-1:0]         beat_len;
  logic [CW-1:0]         frame_len;
  logic [CW-1:0]         need;

  function automatic logic [CW-1:0] popcnt(input logic [KEEP_WIDTH-1:0] k);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      n = n + CW'(k[i]);
    end
    return n;
  endfunction

  // Contiguous byte enables covering the low n bytes of a beat.
  function automatic logic [KEEP_WIDTH-1:0] keep_low(input logic [CW-1:0] n);
    logic [KEEP_WIDTH-1:0] k;
    k = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      k[i] = (CW'(i) < n);
    end
    return k;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mask_data(
    input logic [DATA_WIDTH-1:0] d,
    input logic [KEEP_WIDTH-1:0] k
  );
    logic [DATA_WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      r[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
    end
    return r;
  endfunction

  // Output register can take a new beat when empty or being drained.
  assign out_free  = m_axis_tready || !m_valid_q;
  assign s_ready   = aresetn && (state_q == ST_PASS) && out_free;
  assign s_fire    = s_ready && s_axis_tvalid;
  assign beat_len  = popcnt(s_axis_tkeep);
  assign frame_len = cnt_q + beat_len;
  // Only consulted while cnt_q < MIN_LEN, so never wraps in use.
  assign need      = MIN_LEN - cnt_q;

  // Next-state, byte accounting and output-register load decisions.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    user_lat_d = user_lat_q;
    m_data_d   = m_data_q;
    m_keep_d   = m_keep_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    m_user_d   = m_user_q;

    if (out_free) begin
      m_valid_d = 1'b0;
    end

    case (state_q)
      ST_PASS: begin
        if (s_fire) begin
          m_valid_d = 1'b1;
          m_user_d  = '0;
          if (!s_axis_tlast) begin
            m_data_d = s_axis_tdata;
            m_keep_d = s_axis_tkeep;
            m_last_d = 1'b0;
            cnt_d    = (frame_len >= MIN_LEN) ? MIN_LEN : frame_len;
          end else if (frame_len >= MIN_LEN) begin
            m_data_d = s_axis_tdata;
            m_keep_d = s_axis_tkeep;
            m_last_d = 1'b1;
            m_user_d = s_axis_tuser;
            cnt_d    = '0;
            // An empty closing beat on an already long frame still has to
            // carry tlast; send it as a single zero byte rather than a
            // beat with no enables, which the MAC would not accept.
            if (s_axis_tkeep == '0) begin
              m_data_d = '0;
              m_keep_d = KEEP_WIDTH'(1);
            end
          end else begin
            m_data_d = mask_data(s_axis_tdata, s_axis_tkeep);
            if (need <= BEAT_BYTES) begin
              m_keep_d = keep_low(need);
              m_last_d = 1'b1;
              m_user_d = s_axis_tuser;
              cnt_d    = '0;
            end else begin
              // Whole beat goes out; remaining padding follows in ST_PAD.
              m_keep_d   = '1;
              m_last_d   = 1'b0;
              user_lat_d = s_axis_tuser;
              cnt_d      = cnt_q + BEAT_BYTES;
              state_d    = ST_PAD;
            end
          end
        end
      end

      ST_PAD: begin
        if (out_free) begin
          m_valid_d = 1'b1;
          m_data_d  = '0;
          if (need <= BEAT_BYTES) begin
            m_keep_d = keep_low(need);
            m_last_d = 1'b1;
            m_user_d = user_lat_q;
            cnt_d    = '0;
            state_d  = ST_PASS;
          end else begin
            m_keep_d = '1;
            m_last_d = 1'b0;
            m_user_d = '0;
            cnt_d    = cnt_q + BEAT_BYTES;
          end
        end
      end

      default: begin
        state_d = ST_PASS;
      end
    endcase
  end

  // State, counter and registered outputs; reset abandons any frame.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= ST_PASS;
      cnt_q      <= '0;
      user_lat_q <= '0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_user_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      user_lat_q <= user_lat_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      m_user_q   <= m_user_d;
    end
  end

  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tkeep  = m_keep_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign m_axis_tuser  = m_user_q;

endmodule
